// File: rtl/cdbus_irq_coalesce_if.sv
// Host CSR bus for the interrupt controller: word-addressed, byte-enabled writes
// and a combinational read-data return.
interface cdbus_irq_coalesce_if;
  logic [2:0]  csr_address;
  logic [3:0]  csr_byteenable;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;

  modport master (
    output csr_address,
    output csr_byteenable,
    output csr_read,
    output csr_write,
    output csr_writedata,
    input  csr_readdata
  );

  modport slave (
    input  csr_address,
    input  csr_byteenable,
    input  csr_read,
    input  csr_write,
    input  csr_writedata,
    output csr_readdata
  );
endinterface

// File: rtl/cdbus_irq_coalesce.sv
// N-source interrupt controller: per-source level/sticky status with write-1-to-clear,
// and an irq output coalesced by event count or prescaled timeout.
module cdbus_irq_coalesce #(
  parameter int N_SRC = 7,
  parameter int EVT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC-1:0]    src_level,
  cdbus_irq_coalesce_if.slave csr,
  output logic                irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_MASK     = 3'd1;
  localparam logic [2:0] A_MODE     = 3'd2;
  localparam logic [2:0] A_CLEAR    = 3'd3;
  localparam logic [2:0] A_COAL     = 3'd4;
  localparam logic [2:0] A_PRESCALE = 3'd5;
  localparam logic [2:0] A_DEBUG    = 3'd6;

  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] status_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] clr_bits;
  logic [EVT_W-1:0] thresh_q;
  logic [EVT_W-1:0] evcnt;
  logic [TMR_W-1:0] timeout_q;
  logic [TMR_W-1:0] prescale_q;
  logic [TMR_W-1:0] presc_cnt;
  logic [TMR_W-1:0] timer;
  state_t           state;

  logic [31:0] be_mask;
  logic [31:0] coal_img;
  logic [31:0] rd_mux;
  logic        wr_mask;
  logic        wr_mode;
  logic        wr_clear;
  logic        wr_coal;
  logic        wr_presc;
  logic        evt;
  logic        tick;
  logic        fire_now;
  logic        any_pending;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] lanes);
    return (old_v & ~lanes) | (new_v & lanes);
  endfunction

  assign be_mask  = {{8{csr.csr_byteenable[3]}}, {8{csr.csr_byteenable[2]}},
                     {8{csr.csr_byteenable[1]}}, {8{csr.csr_byteenable[0]}}};
  assign coal_img = (32'(timeout_q) << 16) | 32'(thresh_q);

  assign wr_mask  = csr.csr_write && (csr.csr_address == A_MASK);
  assign wr_mode  = csr.csr_write && (csr.csr_address == A_MODE);
  assign wr_clear = csr.csr_write && (csr.csr_address == A_CLEAR);
  assign wr_coal  = csr.csr_write && (csr.csr_address == A_COAL);
  assign wr_presc = csr.csr_write && (csr.csr_address == A_PRESCALE);

  assign clr_bits = wr_clear ? N_SRC'(csr.csr_writedata & be_mask) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      mode_q     <= '0;
      thresh_q   <= EVT_W'(1);
      timeout_q  <= '0;
      prescale_q <= '0;
    end else begin
      if (wr_mask)
        mask_q <= N_SRC'(lane_merge(32'(mask_q), csr.csr_writedata, be_mask));
      if (wr_mode)
        mode_q <= N_SRC'(lane_merge(32'(mode_q), csr.csr_writedata, be_mask));
      if (wr_coal) begin
        thresh_q  <= EVT_W'(lane_merge(coal_img, csr.csr_writedata, be_mask));
        timeout_q <= TMR_W'(lane_merge(coal_img, csr.csr_writedata, be_mask) >> 16);
      end
      if (wr_presc)
        prescale_q <= TMR_W'(lane_merge(32'(prescale_q), csr.csr_writedata, be_mask));
    end
  end

  // Sticky bits hold until cleared, but a concurrent set beats the clear; level bits
  // just follow the input, which also drops any latch when a source leaves sticky mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q  <= '0;
      pending_q <= '0;
    end else begin
      status_q  <= src_level | (mode_q & status_q & ~clr_bits);
      pending_q <= pending;
    end
  end

  assign pending     = status_q & mask_q;
  assign any_pending = |pending;
  assign evt         = |(pending & ~pending_q);
  assign tick        = (presc_cnt >= prescale_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc_cnt <= '0;
    else if ((state == ST_IDLE) && any_pending)
      presc_cnt <= '0;
    else if (tick)
      presc_cnt <= '0;
    else
      presc_cnt <= presc_cnt + TMR_W'(1);
  end

  assign fire_now = (evcnt >= thresh_q) || (thresh_q == '0) ||
                    ((timeout_q != '0) && (timer >= timeout_q));

  // A pending drop always wins over a fire decision in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      evcnt <= '0;
      timer <= '0;
      irq   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          evcnt <= '0;
          timer <= '0;
          irq   <= 1'b0;
          if (any_pending) begin
            state <= ST_ACCUM;
            evcnt <= EVT_W'(evt);
          end
        end
        ST_ACCUM: begin
          if (!any_pending) begin
            state <= ST_IDLE;
            evcnt <= '0;
            timer <= '0;
          end else if (fire_now) begin
            state <= ST_FIRE;
            irq   <= 1'b1;
          end else begin
            if (evt && (evcnt != '1))
              evcnt <= evcnt + EVT_W'(1);
            if (tick && (timer != '1))
              timer <= timer + TMR_W'(1);
          end
        end
        ST_FIRE: begin
          if (!any_pending) begin
            state <= ST_IDLE;
            evcnt <= '0;
            timer <= '0;
            irq   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          evcnt <= '0;
          timer <= '0;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr.csr_address)
      A_STATUS:   rd_mux = 32'(status_q);
      A_MASK:     rd_mux = 32'(mask_q);
      A_MODE:     rd_mux = 32'(mode_q);
      A_CLEAR:    rd_mux = '0;
      A_COAL:     rd_mux = coal_img;
      A_PRESCALE: rd_mux = 32'(prescale_q);
      A_DEBUG:    rd_mux = {16'h0000, 8'(evcnt), 6'b000000, state};
      default:    rd_mux = '0;
    endcase
  end

  assign csr.csr_readdata = csr.csr_read ? rd_mux : '0;

endmodule

// File: tb/tb_cdbus_irq_coalesce.sv
// Directed and randomized checks of cdbus_irq_coalesce against a cycle-level
// behavioural model of the status, coalescing and register rules.
module tb_cdbus_irq_coalesce;
  localparam int N_SRC = 7;
  localparam int EVT_W = 8;
  localparam int TMR_W = 16;
  localparam logic [31:0] SRC_ALL = 32'h0000_007F;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_SRC-1:0] src_level = '0;
  logic             irq;

  cdbus_irq_coalesce_if bus ();

  cdbus_irq_coalesce #(.N_SRC(N_SRC), .EVT_W(EVT_W), .TMR_W(TMR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_level (src_level),
    .csr       (bus),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  typedef enum {M_QUIET, M_GATHER, M_ALERT} mphase_t;

  mphase_t     m_phase;
  logic [31:0] m_mask, m_mode, m_status, m_prev_pend;
  int unsigned m_thresh, m_timeout, m_prescale, m_events, m_age;

  function automatic logic [31:0] apply_lanes(input logic [31:0] old_v,
                                              input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = M_QUIET;
    m_mask      = '0;
    m_mode      = '0;
    m_status    = '0;
    m_prev_pend = '0;
    m_thresh    = 1;
    m_timeout   = 0;
    m_prescale  = 0;
    m_events    = 0;
    m_age       = 0;
  endtask

  // One clock edge of the model; the timer is derived from time spent gathering,
  // since the prescaler restarts on entry and the prescale is held during a run.
  task automatic model_step();
    logic [31:0] pend, clr, coal;
    logic        rise;
    int unsigned tmr;
    pend = m_status & m_mask;
    rise = ((pend & ~m_prev_pend) != 0);
    tmr  = m_age / (m_prescale + 1);
    case (m_phase)
      M_QUIET: if (pend != 0) begin
        m_phase  = M_GATHER;
        m_events = rise ? 1 : 0;
        m_age    = 0;
      end
      M_GATHER: begin
        if (pend == 0) begin
          m_phase  = M_QUIET;
          m_events = 0;
        end else if (m_events >= m_thresh || m_thresh == 0 ||
                     (m_timeout != 0 && tmr >= m_timeout)) begin
          m_phase = M_ALERT;
        end else begin
          if (rise && m_events < (1 << EVT_W) - 1) m_events++;
          m_age++;
        end
      end
      M_ALERT: if (pend == 0) begin
        m_phase  = M_QUIET;
        m_events = 0;
      end
      default: m_phase = M_QUIET;
    endcase
    clr = '0;
    if (bus.csr_write && bus.csr_address == 3'd3)
      clr = apply_lanes(32'h0, bus.csr_writedata, bus.csr_byteenable);
    for (int i = 0; i < N_SRC; i++) begin
      if (m_mode[i]) m_status[i] = src_level[i] | (m_status[i] & ~clr[i]);
      else           m_status[i] = src_level[i];
    end
    if (bus.csr_write) begin
      case (bus.csr_address)
        3'd1: m_mask = apply_lanes(m_mask, bus.csr_writedata, bus.csr_byteenable) & SRC_ALL;
        3'd2: m_mode = apply_lanes(m_mode, bus.csr_writedata, bus.csr_byteenable) & SRC_ALL;
        3'd4: begin
          coal      = apply_lanes((m_timeout << 16) | m_thresh, bus.csr_writedata,
                                  bus.csr_byteenable);
          m_thresh  = coal & 32'hFF;
          m_timeout = coal >> 16;
        end
        3'd5: m_prescale = apply_lanes(m_prescale, bus.csr_writedata, bus.csr_byteenable)
                           & 32'hFFFF;
        default: ;
      endcase
    end
    m_prev_pend = pend;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    @(negedge clk);
    check("irq_vs_model", {31'd0, irq}, {31'd0, m_phase == M_ALERT});
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.csr_address    = a;
    bus.csr_byteenable = be;
    bus.csr_writedata  = d;
    bus.csr_write      = 1'b1;
    step();
    bus.csr_write      = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.csr_address = a;
    bus.csr_read    = 1'b1;
    #1;
    check(tag, bus.csr_readdata, exp);
    bus.csr_read    = 1'b0;
  endtask

  task automatic read_dbg(output logic [31:0] v);
    bus.csr_address = 3'd6;
    bus.csr_read    = 1'b1;
    #1;
    v = bus.csr_readdata;
    bus.csr_read    = 1'b0;
  endtask

  initial begin
    logic [31:0] dbg;
    int          fired_at;
    int          r;

    bus.csr_address    = '0;
    bus.csr_byteenable = '0;
    bus.csr_read       = 1'b0;
    bus.csr_write      = 1'b0;
    bus.csr_writedata  = '0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();

    // Register defaults.
    csr_chk("rst_mask", 3'd1, 32'h0);
    csr_chk("rst_mode", 3'd2, 32'h0);
    csr_chk("rst_coal", 3'd4, 32'h0000_0001);
    csr_chk("rst_prescale", 3'd5, 32'h0);
    csr_chk("rst_debug", 3'd6, 32'h0);

    // Sticky capture of a one-cycle pulse, then write-1-to-clear.
    csr_wr(3'd2, 4'hF, 32'h7F);
    csr_wr(3'd1, 4'hF, 32'h01);
    src_level = 7'h01;
    step();
    src_level = 7'h00;
    check("sticky_irq_n1", {31'd0, irq}, 32'd0);
    step();
    check("sticky_irq_n2", {31'd0, irq}, 32'd0);
    step();
    check("sticky_irq_n3", {31'd0, irq}, 32'd1);
    csr_chk("sticky_status", 3'd0, 32'h01);
    csr_wr(3'd3, 4'hF, 32'h01);
    check("clear_irq_m1", {31'd0, irq}, 32'd1);
    step();
    check("clear_irq_m2", {31'd0, irq}, 32'd0);

    // Reset in the middle of FIRE drops irq without waiting for a clock.
    src_level = 7'h01;
    step();
    src_level = 7'h00;
    step();
    step();
    check("pre_reset_fire", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_async_irq", {31'd0, irq}, 32'd0);
    model_reset();
    step();
    reset = 1'b0;
    step();
    csr_chk("post_rst_mask", 3'd1, 32'h0);
    csr_chk("post_rst_coal", 3'd4, 32'h0000_0001);
    src_level = 7'h7F;
    repeat (6) step();
    check("masked_no_irq", {31'd0, irq}, 32'd0);
    csr_chk("level_status", 3'd0, 32'h7F);
    src_level = 7'h00;
    step();

    // Count coalescing: four separate events reach a threshold of four.
    csr_wr(3'd2, 4'hF, 32'h7F);
    csr_wr(3'd1, 4'hF, 32'h0F);
    csr_wr(3'd4, 4'hF, 32'h0000_0004);
    for (int k = 0; k < 3; k++) begin
      src_level = 7'(1 << k);
      step();
      src_level = 7'h00;
      step();
    end
    check("count_before_4th", {31'd0, irq}, 32'd0);
    src_level = 7'h08;
    step();
    src_level = 7'h00;
    step();
    check("count_4th_p1", {31'd0, irq}, 32'd0);
    step();
    check("count_4th_p2", {31'd0, irq}, 32'd1);
    csr_wr(3'd3, 4'hF, 32'h0F);
    step();
    check("count_cleared", {31'd0, irq}, 32'd0);

    // Four sources rising together are a single event.
    src_level = 7'h0F;
    step();
    src_level = 7'h00;
    repeat (12) step();
    check("same_cycle_no_irq", {31'd0, irq}, 32'd0);
    read_dbg(dbg);
    check("same_cycle_evcnt", (dbg >> 8) & 32'hFF, 32'd1);
    csr_wr(3'd3, 4'hF, 32'h0F);
    step();

    // Timeout coalescing: 3 ticks of 10 cycles.
    csr_wr(3'd4, 4'hF, 32'h0003_0008);
    csr_wr(3'd5, 4'hF, 32'd9);
    src_level = 7'h01;
    step();
    src_level = 7'h00;
    fired_at = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (irq && fired_at == 0) fired_at = i;
    end
    check("timeout_window", {31'd0, (fired_at >= 31) && (fired_at <= 33)}, 32'd1);
    csr_wr(3'd3, 4'hF, 32'h0F);
    step();

    // Level source dropping before the threshold is reached.
    csr_wr(3'd2, 4'hF, 32'h00);
    csr_wr(3'd1, 4'hF, 32'h02);
    csr_wr(3'd4, 4'hF, 32'h0000_0002);
    src_level = 7'h02;
    step();
    step();
    step();
    read_dbg(dbg);
    check("level_accum_state", {31'd0, (dbg & 32'h3) != 0}, 32'd1);
    step();
    step();
    src_level = 7'h00;
    repeat (3) step();
    read_dbg(dbg);
    check("level_back_idle", dbg & 32'h3, 32'd0);
    check("level_no_irq", {31'd0, irq}, 32'd0);

    // Set and clear of the same sticky bit in one cycle: set wins.
    csr_wr(3'd2, 4'hF, 32'h7F);
    csr_wr(3'd1, 4'hF, 32'h04);
    csr_wr(3'd4, 4'hF, 32'h0000_0001);
    src_level = 7'h04;
    repeat (4) step();
    check("setclr_pre_irq", {31'd0, irq}, 32'd1);
    csr_wr(3'd3, 4'hF, 32'h04);
    step();
    csr_chk("setclr_status", 3'd0, 32'h04);
    check("setclr_irq", {31'd0, irq}, 32'd1);
    src_level = 7'h00;
    csr_wr(3'd3, 4'hF, 32'h04);
    step();
    check("setclr_released", {31'd0, irq}, 32'd0);

    // Byte-lane gating and field boundaries.
    csr_wr(3'd4, 4'b0001, 32'hFFFF_FF05);
    csr_chk("be_thresh_only", 3'd4, 32'h0000_0005);
    csr_wr(3'd4, 4'b0100, 32'h00AB_0000);
    csr_chk("be_timeout_lo", 3'd4, 32'h00AB_0005);
    csr_wr(3'd4, 4'b1000, 32'hFF00_0000);
    csr_chk("be_timeout_hi", 3'd4, 32'hFFAB_0005);
    csr_wr(3'd1, 4'b0010, 32'hFFFF_FFFF);
    csr_chk("be_mask_upper", 3'd1, 32'h04);
    csr_wr(3'd1, 4'hF, 32'hFFFF_FFFF);
    csr_chk("mask_width", 3'd1, 32'h7F);
    csr_chk("clear_reads_0", 3'd3, 32'h0);
    csr_chk("addr7_reads_0", 3'd7, 32'h0);

    // Randomized runs, each from reset with a fixed prescale.
    for (int seg = 0; seg < 8; seg++) begin
      reset = 1'b1;
      model_reset();
      step();
      reset = 1'b0;
      csr_wr(3'd1, 4'hF, $urandom & 32'h7F);
      csr_wr(3'd2, 4'hF, $urandom);
      csr_wr(3'd4, 4'hF, (32'($urandom_range(0, 4)) << 16) | 32'($urandom_range(0, 5)));
      csr_wr(3'd5, 4'hF, 32'($urandom_range(0, 3)));
      for (int c = 0; c < 150; c++) begin
        csr_chk("rnd_status", 3'd0, m_status);
        read_dbg(dbg);
        check("rnd_evcnt", (dbg >> 8) & 32'hFF, m_events & 32'hFF);
        src_level = N_SRC'($urandom & $urandom & $urandom);
        r = $urandom_range(0, 99);
        if (r < 10)
          csr_wr(3'd3, 4'(($urandom_range(0, 15))), $urandom);
        else if (r < 14)
          csr_wr(3'd1, 4'hF, $urandom);
        else if (r < 17)
          csr_wr(3'd4, 4'b0001, 32'($urandom_range(0, 6)));
        else
          step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
